// File: rtl/ram256x8.sv
// 256 x 8 byte-addressed RAM with big-endian 1/2/4/8-byte accesses, one-cycle moc handshake.
// Build option: define RAM256X8_ALIGN_EN to force natural alignment of multi-byte accesses.
module ram256x8 (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] DaIn,
  output logic [63:0] DaOut,
  input  logic        rw,
  input  logic [7:0]  address,
  input  logic        mv,
  output logic        moc,
  input  logic        enable,
  input  logic [1:0]  typeData
);

  logic [7:0]  mem [0:255];

  logic        accept;
  logic [7:0]  base_addr;
  logic [3:0]  nbytes;
  logic [5:0]  lane_shift;
  logic [63:0] win;
  logic [63:0] rd_data;
  logic [63:0] wr_aligned;
  logic [7:0]  we;
  logic [7:0]  waddr [0:7];
  logic [7:0]  wbyte [0:7];

  // moc gates acceptance, so at most one operation completes every two cycles
  assign accept = enable && mv && !moc && !reset;

  always_comb begin
    nbytes     = 4'd1;
    lane_shift = 6'd56;
    case (typeData)
      2'b00: begin nbytes = 4'd1; lane_shift = 6'd56; end
      2'b01: begin nbytes = 4'd2; lane_shift = 6'd48; end
      2'b10: begin nbytes = 4'd4; lane_shift = 6'd32; end
      2'b11: begin nbytes = 4'd8; lane_shift = 6'd0;  end
      default: begin nbytes = 4'd1; lane_shift = 6'd56; end
    endcase
  end

`ifdef RAM256X8_ALIGN_EN
  always_comb begin
    base_addr = address;
    case (typeData)
      2'b01:   base_addr = {address[7:1], 1'b0};
      2'b10:   base_addr = {address[7:2], 2'b00};
      2'b11:   base_addr = {address[7:3], 3'b000};
      default: base_addr = address;
    endcase
  end
`else
  assign base_addr = address;
`endif

  // Eight-byte big-endian window starting at base_addr; the 8-bit address add wraps mod 256
  assign wr_aligned = DaIn << lane_shift;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign waddr[k]            = base_addr + 8'(k);
    assign win[63-8*k -: 8]    = mem[waddr[k]];
    assign wbyte[k]            = wr_aligned[63-8*k -: 8];
    assign we[k]               = (4'(k) < nbytes);
  end

  assign rd_data = win >> lane_shift;

  // Storage is deliberately not reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (accept && !rw) begin
      for (int k = 0; k < 8; k++) begin
        if (we[k]) mem[waddr[k]] <= wbyte[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      moc   <= 1'b0;
      DaOut <= 64'd0;
    end else begin
      moc <= accept;
      if (accept && rw) DaOut <= rd_data;
    end
  end

endmodule

// File: tb/tb_ram256x8.sv
// Directed self-checking bench for ram256x8; expectations follow the RAM256X8_ALIGN_EN setting.
module tb_ram256x8;

  logic        clk;
  logic        reset;
  logic [63:0] DaIn;
  logic [63:0] DaOut;
  logic        rw;
  logic [7:0]  address;
  logic        mv;
  logic        moc;
  logic        enable;
  logic [1:0]  typeData;

  int total = 0;
  int bad   = 0;

  ram256x8 dut (
    .clk(clk), .reset(reset), .DaIn(DaIn), .DaOut(DaOut), .rw(rw),
    .address(address), .mv(mv), .moc(moc), .enable(enable), .typeData(typeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request at a negedge, drop mv after acceptance, return once moc has fallen
  task automatic do_op(input logic r, input logic [1:0] t, input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    rw = r; typeData = t; address = a; DaIn = d; mv = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    mv = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mv = 1'b0; enable = 1'b0; rw = 1'b1; address = 8'h00;
    typeData = 2'b00; DaIn = 64'd0;
    #2 reset = 1'b1;
    #1;
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL reset_moc got=%b want=0", moc); end
    total++; if (DaOut !== 64'd0) begin bad++; $display("FAIL reset_daout got=%h want=0", DaOut); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_dword_read();
    for (int i = 0; i < 8; i++) dut.mem[i] = 8'(i + 1);
    @(negedge clk);
    rw = 1'b1; typeData = 2'b11; address = 8'h00; mv = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    mv = 1'b0;
    total++; if (moc !== 1'b1) begin bad++; $display("FAIL dword_moc_rise got=%b want=1", moc); end
    total++; if (DaOut !== 64'h0102030405060708) begin bad++; $display("FAIL dword_read got=%h want=0102030405060708", DaOut); end
    @(posedge clk); #1;
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL dword_moc_fall got=%b want=0", moc); end
  endtask

  task automatic test_byte();
    do_op(1'b0, 2'b00, 8'h02, 64'hFFFF_FFFF_FFFF_FF9B);
    do_op(1'b1, 2'b00, 8'h02, 64'd0);
    total++; if (DaOut !== 64'h9B) begin bad++; $display("FAIL byte_read got=%h want=9b", DaOut); end
    total++; if (dut.mem[1] !== 8'h02) begin bad++; $display("FAIL byte_mem1 got=%h want=02", dut.mem[1]); end
    total++; if (dut.mem[3] !== 8'h04) begin bad++; $display("FAIL byte_mem3 got=%h want=04", dut.mem[3]); end
  endtask

  task automatic test_halfword();
    do_op(1'b0, 2'b01, 8'h04, 64'h1234_5678_9ABC_BEBF);
    total++; if (dut.mem[4] !== 8'hBE) begin bad++; $display("FAIL half_mem4 got=%h want=be", dut.mem[4]); end
    total++; if (dut.mem[5] !== 8'hBF) begin bad++; $display("FAIL half_mem5 got=%h want=bf", dut.mem[5]); end
    total++; if (dut.mem[6] !== 8'h07) begin bad++; $display("FAIL half_mem6 got=%h want=07", dut.mem[6]); end
    do_op(1'b1, 2'b01, 8'h04, 64'd0);
    total++; if (DaOut !== 64'hBEBF) begin bad++; $display("FAIL half_read got=%h want=bebf", DaOut); end
  endtask

  task automatic test_dword_word();
    do_op(1'b0, 2'b11, 8'h08, 64'hCAFE_FEAF_BEBE_ABEF);
    total++; if (DaOut !== 64'hBEBF) begin bad++; $display("FAIL write_holds_daout got=%h want=bebf", DaOut); end
    total++; if (dut.mem[8] !== 8'hCA) begin bad++; $display("FAIL dword_mem8 got=%h want=ca", dut.mem[8]); end
    do_op(1'b1, 2'b10, 8'h0C, 64'd0);
    total++; if (DaOut !== 64'hBEBE_ABEF) begin bad++; $display("FAIL word_read got=%h want=bebeabef", DaOut); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rw = 1'b0; typeData = 2'b00; address = 8'h40; DaIn = 64'h5A; mv = 1'b1; enable = 1'b1;
    @(posedge clk); #1;
    rw = 1'b1; DaIn = 64'hEE;
    @(posedge clk); #1;
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", moc); end
    @(posedge clk); #1;
    mv = 1'b0;
    total++; if (moc !== 1'b1) begin bad++; $display("FAIL b2b_moc got=%b want=1", moc); end
    total++; if (DaOut !== 64'h5A) begin bad++; $display("FAIL b2b_read got=%h want=5a", DaOut); end
    @(posedge clk); #1;
  endtask

  task automatic test_enable();
    @(negedge clk);
    enable = 1'b0; mv = 1'b1; rw = 1'b0; typeData = 2'b00; address = 8'h40; DaIn = 64'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++; if (moc !== 1'b0) begin bad++; $display("FAIL disabled_moc cycle=%0d got=%b want=0", i, moc); end
    end
    total++; if (dut.mem[8'h40] !== 8'h5A) begin bad++; $display("FAIL disabled_mem got=%h want=5a", dut.mem[8'h40]); end
    total++; if (DaOut !== 64'h5A) begin bad++; $display("FAIL disabled_daout got=%h want=5a", DaOut); end
    mv = 1'b0; enable = 1'b1;
  endtask

  task automatic test_wrap();
    do_op(1'b0, 2'b10, 8'hFE, 64'hAAAA_AAAA_1122_3344);
`ifdef RAM256X8_ALIGN_EN
    total++; if (dut.mem[8'hFC] !== 8'h11) begin bad++; $display("FAIL wrap_fc got=%h want=11", dut.mem[8'hFC]); end
    total++; if (dut.mem[8'hFD] !== 8'h22) begin bad++; $display("FAIL wrap_fd got=%h want=22", dut.mem[8'hFD]); end
    total++; if (dut.mem[8'hFE] !== 8'h33) begin bad++; $display("FAIL wrap_fe got=%h want=33", dut.mem[8'hFE]); end
    total++; if (dut.mem[8'hFF] !== 8'h44) begin bad++; $display("FAIL wrap_ff got=%h want=44", dut.mem[8'hFF]); end
    total++; if (dut.mem[0] !== 8'h01) begin bad++; $display("FAIL wrap_00 got=%h want=01", dut.mem[0]); end
`else
    total++; if (dut.mem[8'hFE] !== 8'h11) begin bad++; $display("FAIL wrap_fe got=%h want=11", dut.mem[8'hFE]); end
    total++; if (dut.mem[8'hFF] !== 8'h22) begin bad++; $display("FAIL wrap_ff got=%h want=22", dut.mem[8'hFF]); end
    total++; if (dut.mem[0] !== 8'h33) begin bad++; $display("FAIL wrap_00 got=%h want=33", dut.mem[0]); end
    total++; if (dut.mem[1] !== 8'h44) begin bad++; $display("FAIL wrap_01 got=%h want=44", dut.mem[1]); end
    total++; if (dut.mem[2] !== 8'h9B) begin bad++; $display("FAIL wrap_02 got=%h want=9b", dut.mem[2]); end
`endif
    do_op(1'b1, 2'b10, 8'hFE, 64'd0);
    total++; if (DaOut !== 64'h1122_3344) begin bad++; $display("FAIL wrap_read got=%h want=11223344", DaOut); end
    do_op(1'b1, 2'b00, 8'hFF, 64'd0);
`ifdef RAM256X8_ALIGN_EN
    total++; if (DaOut !== 64'h44) begin bad++; $display("FAIL byte_ff got=%h want=44", DaOut); end
`else
    total++; if (DaOut !== 64'h22) begin bad++; $display("FAIL byte_ff got=%h want=22", DaOut); end
`endif
  endtask

  task automatic test_hold_and_reset();
    logic [63:0] exp_byte0;
`ifdef RAM256X8_ALIGN_EN
    exp_byte0 = 64'h01;
`else
    exp_byte0 = 64'h33;
`endif
    @(negedge clk);
    enable = 1'b1; mv = 1'b1; rw = 1'b1; typeData = 2'b00; address = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      total++;
      if (moc !== ((i % 2) == 0)) begin bad++; $display("FAIL hold_moc cycle=%0d got=%b want=%b", i + 1, moc, ((i % 2) == 0)); end
    end
    @(posedge clk); #1;
    total++; if (moc !== 1'b1) begin bad++; $display("FAIL hold_moc cycle=7 got=%b want=1", moc); end
    total++; if (DaOut !== exp_byte0) begin bad++; $display("FAIL hold_read got=%h want=%h", DaOut, exp_byte0); end
    #1 reset = 1'b1;
    #1;
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL async_reset_moc got=%b want=0", moc); end
    total++; if (DaOut !== 64'd0) begin bad++; $display("FAIL async_reset_daout got=%h want=0", DaOut); end
    @(posedge clk); #1;
    total++; if (moc !== 1'b0) begin bad++; $display("FAIL reset_blocks_req got=%b want=0", moc); end
    total++; if (dut.mem[8'h40] !== 8'h5A) begin bad++; $display("FAIL mem_retained got=%h want=5a", dut.mem[8'h40]); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    total++; if (moc !== 1'b1) begin bad++; $display("FAIL first_after_reset got=%b want=1", moc); end
    total++; if (DaOut !== exp_byte0) begin bad++; $display("FAIL read_after_reset got=%h want=%h", DaOut, exp_byte0); end
    mv = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_dword_read();
    test_byte();
    test_halfword();
    test_dword_word();
    test_back_to_back();
    test_enable();
    test_wrap();
    test_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram256x8.md
RAM256X8 -- requirements
Module: ram256x8

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 256 bytes x 8 bits, byte-addressed.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 DaIn  input  64  write data, right-justified per size.
REQ-006 DaOut  output  64  read data, right-justified and zero-extended.
REQ-007 rw  input  1  operation select: 0 = write, 1 = read.
REQ-008 address  input  8  byte address of the first (most significant) byte.
REQ-009 mv  input  1  memory operation valid (level request).
REQ-010 moc  output  1  memory operation complete (one-cycle pulse).
REQ-011 enable  input  1  chip enable; requests are ignored while 0.
REQ-012 typeData  input  2  size: 00 byte, 01 halfword (2 B), 10 word (4 B), 11 doubleword (8 B).
REQ-013 Storage SHALL be a 256-entry, 8-bit array named mem, indexable hierarchically as mem[0..255] so a bench can preload it.

Function
REQ-014 A request SHALL be accepted on a rising clk edge where enable=1, mv=1 and moc=0.
REQ-015 At the accepting edge, moc SHALL go to 1; at the next edge it SHALL return to 0, giving a one-cycle pulse and a latency of 1 cycle.
REQ-016 While moc=1, no request SHALL be accepted; if mv stays high, the next acceptance is the edge after moc falls, so at most one operation completes every 2 cycles.
REQ-017 Byte order SHALL be big-endian: mem[a] holds the most significant byte of the addressed item; N = 1, 2, 4 or 8 bytes per typeData.
REQ-018 Write (rw=0): at the accepting edge, mem[a+k] SHALL be set to DaIn byte (N-1-k) for k=0..N-1; DaIn bits above 8N are ignored, other locations are unchanged, and DaOut holds its value.
REQ-019 Read (rw=1): at the accepting edge, DaOut SHALL load {mem[a], ..., mem[a+N-1]} in bits [8N-1:0], with the upper bits set to 0.
REQ-020 Address arithmetic a+k SHALL wrap modulo 256; for example, a word at 0xFE covers bytes FE, FF, 00, 01.
REQ-021 A read accepted at the edge after a write SHALL return the newly written data.
REQ-022 With enable=0 or mv=0, no state SHALL change except the moc pulse falling; DaOut holds its value.
REQ-023 Changes to address, rw, typeData or DaIn while no request is being accepted SHALL have no effect.

Reset
REQ-024 reset=1 SHALL immediately force moc=0 and DaOut=0, independent of clk.
REQ-025 mem SHALL NOT be reset; contents persist across reset.
REQ-026 A write completed at an edge before reset was asserted SHALL remain in mem; no request SHALL be accepted while reset=1.
REQ-027 After reset is released, the first request SHALL be accepted at the first qualifying edge.

Configuration
REQ-028 Macro RAM256X8_ALIGN_EN:
- Defined: the effective address SHALL be forced to natural alignment by clearing address bits [0], [1:0] or [2:0] for halfword, word or doubleword respectively.
- Undefined: unaligned addresses SHALL be used as given, with the wrap of REQ-020.
- Byte accesses and the interface are identical in both builds.

Verification
REQ-029 Preload mem[0..7]=01..08, then read doubleword at 0x00 -> one moc pulse, DaOut=0x0102030405060708.
REQ-030 Write byte 0x9B at 0x02, then read byte at 0x02 -> DaOut=0x000000000000009B; mem[1] and mem[3] unchanged.
REQ-031 Write halfword 0xBEBF at 0x04, then read -> mem[4]=BE, mem[5]=BF, DaOut=0x000000000000BEBF.
REQ-032 Write doubleword 0xCAFEFEAFBEBEABEF at 0x08, then read word at 0x0C -> DaOut=0x00000000BEBEABEF.
REQ-033 Word write 0x11223344 at 0xFE:
- Without the macro: mem[FE]=11, mem[FF]=22, mem[00]=33, mem[01]=44.
- With the macro: mem[FC..FF]=11,22,33,44.
REQ-034 Hold mv=1 for 6 cycles (enable=1) -> moc pulses on cycles 1, 3 and 5; assert reset during a moc pulse -> moc=0 and DaOut=0 immediately, mem retained.
